cp0_exc_ctrl: RTL

CP0_EXC_CTRL -- requirements
Module: cp0_exc_ctrl

---
 rtl/cp0_pkg.sv | 24 ++
 rtl/cp0_exc_prio.sv | 50 +++++
 rtl/cp0_exc_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// -----------------------------------------------------------------------------
// cp0_pkg
// Shared definitions for the CP0 exception controller:
//   - MIPS ExcCode values for the events this controller can raise
//   - the exception-sequencer FSM state type
//   - the default exception/interrupt vector address
// -----------------------------------------------------------------------------
package cp0_pkg;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP  = 5'd9;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  localparam logic [31:0] DEFAULT_VECTOR = 32'h8000_0180;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COMMIT   = 2'd1,
    ST_REDIRECT = 2'd2
  } exc_state_e;

endpackage

// File: rtl/cp0_exc_prio.sv
// -----------------------------------------------------------------------------
// cp0_exc_prio
// Purely combinational priority encoder. Decides whether an event is taken
// this cycle and which ExcCode it carries. Synchronous exceptions always beat
// interrupts; among exceptions the order is RI > Ov > Sys > Bp. An interrupt
// is taken only when globally enabled and not already at exception level.
//
// Ports:
//   i_exc_req [3:0]  exception requests: [3] RI, [2] Ov, [1] Sys, [0] Bp
//   i_pending        at least one unmasked interrupt line is asserted
//   i_ie             Status.IE
//   i_exl            Status.EXL
//   o_take           an exception or interrupt is taken
//   o_exccode [4:0]  ExcCode of the taken event (EXC_INT when none)
// -----------------------------------------------------------------------------
module cp0_exc_prio
  import cp0_pkg::*;
(
  input  logic [3:0] i_exc_req,
  input  logic       i_pending,
  input  logic       i_ie,
  input  logic       i_exl,
  output logic       o_take,
  output logic [4:0] o_exccode
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    o_take    = 1'b0;
    o_exccode = EXC_INT;
    if (i_exc_req[3]) begin
      o_take    = 1'b1;
      o_exccode = EXC_RI;
    end else if (i_exc_req[2]) begin
      o_take    = 1'b1;
      o_exccode = EXC_OV;
    end else if (i_exc_req[1]) begin
      o_take    = 1'b1;
      o_exccode = EXC_SYS;
    end else if (i_exc_req[0]) begin
      o_take    = 1'b1;
      o_exccode = EXC_BP;
    end else if (i_ie && !i_exl && i_pending) begin
      o_take    = 1'b1;
      o_exccode = EXC_INT;
    end
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// -----------------------------------------------------------------------------
// cp0_exc_ctrl
// CP0 exception/interrupt sequencer. From IDLE a taken event moves to COMMIT,
// which pulses the architectural side effects for one cycle (Cause, EPC,
// Status.EXL set, pipeline flush), then to REDIRECT, which presents the
// handler vector until fetch acknowledges it. An ERET at exception level goes
// straight to REDIRECT toward the saved EPC and pulses exl_clr.
//
// Parameters:
//   VECTOR_BASE  handler address for exceptions and interrupts
//   CNT_W        width of the optional event counter
//
// Build option:
//   CP0_EXC_STATS_EN  adds output exc_count, a saturating count of COMMITs
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   exc_req [3:0]           RI/Ov/Sys/Bp requests
//   exc_pc [31:0]           PC of the faulting instruction
//   cause_ip, status_im     interrupt pending lines and mask
//   status_ie, status_exl   Status.IE and Status.EXL
//   eret                    ERET retiring
//   epc_in [31:0]           current EPC (ERET target)
//   redirect_ack            fetch accepted the redirect
//   activeexception         one-cycle pulse in COMMIT
//   exccode [4:0]           last taken ExcCode (held between events)
//   epc_we, epc_out         EPC write strobe and data (COMMIT)
//   exl_set, exl_clr        Status.EXL set (COMMIT) / clear (ERET)
//   flush                   pipeline kill (COMMIT and REDIRECT)
//   redirect_valid/pc       new fetch PC (REDIRECT)
//   exc_count               (CP0_EXC_STATS_EN only) saturating COMMIT count
// -----------------------------------------------------------------------------
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] VECTOR_BASE = DEFAULT_VECTOR,
  parameter int          CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        exc_req,
  input  logic [31:0]       exc_pc,
  input  logic [7:0]        cause_ip,
  input  logic [7:0]        status_im,
  input  logic              status_ie,
  input  logic              status_exl,
  input  logic              eret,
  input  logic [31:0]       epc_in,
  input  logic              redirect_ack,
`ifdef CP0_EXC_STATS_EN
  output logic [CNT_W-1:0]  exc_count,
`endif
  output logic              activeexception,
  output logic [4:0]        exccode,
  output logic              epc_we,
  output logic [31:0]       epc_out,
  output logic              exl_set,
  output logic              exl_clr,
  output logic              flush,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc
);

  // A zero-width counter cannot be built; reject it at elaboration.
  if (CNT_W < 1) begin : g_cnt_w_check
    $error("cp0_exc_ctrl: CNT_W must be at least 1");
  end

  exc_state_e  r_state;
  exc_state_e  w_next_state;

  logic [4:0]  r_exccode;
  logic [31:0] r_epc;
  logic [31:0] r_redirect_pc;
  logic        r_exl_clr;

  logic        w_take;
  logic [4:0]  w_code;
  logic        w_idle;
  logic        w_eret_take;

  cp0_exc_prio u_prio (
    .i_exc_req (exc_req),
    .i_pending (|(cause_ip & status_im)),
    .i_ie      (status_ie),
    .i_exl     (status_exl),
    .o_take    (w_take),
    .o_exccode (w_code)
  );

  assign w_idle      = (r_state == ST_IDLE);
  // ERET only matters at exception level and yields to any taken event.
  assign w_eret_take = eret && status_exl && !w_take;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      r_state <= w_next_state;
    end
  end

  // Next-state logic. Requests arriving in COMMIT/REDIRECT are not looked at.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_take)           w_next_state = ST_COMMIT;
        else if (w_eret_take) w_next_state = ST_REDIRECT;
      end
      ST_COMMIT:   w_next_state = ST_REDIRECT;
      ST_REDIRECT: if (redirect_ack) w_next_state = ST_IDLE;
      default:     w_next_state = ST_IDLE;
    endcase
  end

  // Datapath registers captured on event acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: these are a handful of control flops, not a memory array, so
      // they are all reset to give clean zero outputs out of reset.
      r_exccode     <= EXC_INT;
      r_epc         <= '0;
      r_redirect_pc <= '0;
      r_exl_clr     <= 1'b0;
    end else begin
      r_exl_clr <= 1'b0;
      if (w_idle && w_take) begin
        r_exccode <= w_code;
        r_epc     <= exc_pc;
      end
      if (r_state == ST_COMMIT) begin
        r_redirect_pc <= VECTOR_BASE;
      end
      if (w_idle && w_eret_take) begin
        r_redirect_pc <= epc_in;
        r_exl_clr     <= 1'b1;
      end
    end
  end

  // Output decode (Moore on state, plus the held registers).
  always_comb begin
    activeexception = 1'b0;
    epc_we          = 1'b0;
    epc_out         = '0;
    exl_set         = 1'b0;
    flush           = 1'b0;
    redirect_valid  = 1'b0;
    unique case (r_state)
      ST_COMMIT: begin
        activeexception = 1'b1;
        epc_we          = 1'b1;
        epc_out         = r_epc;
        exl_set         = 1'b1;
        flush           = 1'b1;
      end
      ST_REDIRECT: begin
        redirect_valid  = 1'b1;
        flush           = 1'b1;
      end
      default: ;
    endcase
  end

  assign exccode     = r_exccode;
  assign redirect_pc = r_redirect_pc;
  assign exl_clr     = r_exl_clr;

`ifdef CP0_EXC_STATS_EN
  logic [CNT_W-1:0] r_exc_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_exc_count <= '0;
    end else if ((r_state == ST_COMMIT) && (r_exc_count != {CNT_W{1'b1}})) begin
      r_exc_count <= r_exc_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign exc_count = r_exc_count;
`endif

endmodule
